// File: rtl/shot_sequencer.sv
// rtl/shot_sequencer.sv - per-run trigger/acquire shot sequencer between the DSP register bank and the DSP core
module shot_sequencer #(
  parameter int NSHOT_WIDTH   = 32,
  parameter int DELAY_WIDTH   = 16,
  parameter int PERIOD_WIDTH  = 24,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stb_start,
  input  logic                     i_stb_abort,
  input  logic [NSHOT_WIDTH-1:0]   i_nshot,
  input  logic                     i_resetacc,
  input  logic [DELAY_WIDTH-1:0]   i_delayaftertrig,
  input  logic [PERIOD_WIDTH-1:0]  i_shotperiod,
  input  logic [TIMEOUT_WIDTH-1:0] i_acqtimeout,
  input  logic                     i_procdone,
  output logic                     o_trig,
  output logic                     o_acq_en,
  output logic                     o_accclear,
  output logic                     o_busy,
  output logic [NSHOT_WIDTH-1:0]   o_shotcnt,
  output logic                     o_lastshotdone,
  output logic                     o_timeout_err,
  output logic                     o_aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TRIG,
    S_DELAY,
    S_ACQ,
    S_GAP
  } state_t;

  localparam logic [NSHOT_WIDTH-1:0]   N_ONE = NSHOT_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0]   D_ONE = DELAY_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0]  P_ONE = PERIOD_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] T_ONE = TIMEOUT_WIDTH'(1);

  state_t                   r_state;
  logic [NSHOT_WIDTH-1:0]   r_nshot;
  logic [DELAY_WIDTH-1:0]   r_delay;
  logic [PERIOD_WIDTH-1:0]  r_period;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [PERIOD_WIDTH-1:0]  r_pcnt;
  logic [DELAY_WIDTH-1:0]   r_dcnt;
  logic [TIMEOUT_WIDTH-1:0] r_tcnt;
  logic [NSHOT_WIDTH-1:0]   r_shotcnt;
  logic                     r_trig;
  logic                     r_acq_en;
  logic                     r_accclear;
  logic                     r_busy;
  logic                     r_lastshotdone;
  logic                     r_timeout_err;
  logic                     r_aborted;

  logic [NSHOT_WIDTH-1:0]   w_shotcnt_nxt;
  logic                     w_period_met;

  assign w_shotcnt_nxt = r_shotcnt + N_ONE;
  // True when a trigger issued next cycle lands at or after T + shotperiod.
  assign w_period_met  = ({1'b0, r_pcnt} + {{PERIOD_WIDTH{1'b0}}, 1'b1}) >= {1'b0, r_period};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_nshot        <= '0;
      r_delay        <= '0;
      r_period       <= '0;
      r_timeout      <= '0;
      r_pcnt         <= '0;
      r_dcnt         <= '0;
      r_tcnt         <= '0;
      r_shotcnt      <= '0;
      r_trig         <= 1'b0;
      r_acq_en       <= 1'b0;
      r_accclear     <= 1'b0;
      r_busy         <= 1'b0;
      r_lastshotdone <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      r_trig     <= 1'b0;
      r_accclear <= 1'b0;

      if (r_state == S_TRIG) begin
        r_pcnt <= P_ONE;
      end else if (r_state != S_IDLE && r_pcnt != '1) begin
        r_pcnt <= r_pcnt + P_ONE;
      end

      if (r_state != S_IDLE && i_stb_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_acq_en  <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_stb_start) begin
              r_nshot        <= i_nshot;
              r_delay        <= i_delayaftertrig;
              r_period       <= i_shotperiod;
              r_timeout      <= i_acqtimeout;
              r_shotcnt      <= '0;
              r_timeout_err  <= 1'b0;
              r_aborted      <= 1'b0;
              r_lastshotdone <= (i_nshot == '0);
              if (i_nshot != '0) begin
                r_state    <= S_ARM;
                r_busy     <= 1'b1;
                r_accclear <= i_resetacc;
              end
            end
          end
          S_ARM: begin
            r_state <= S_TRIG;
            r_trig  <= 1'b1;
          end
          S_TRIG: begin
            if (r_delay == '0) begin
              r_state  <= S_ACQ;
              r_acq_en <= 1'b1;
              r_tcnt   <= T_ONE;
            end else begin
              r_state <= S_DELAY;
              r_dcnt  <= D_ONE;
            end
          end
          S_DELAY: begin
            if (r_dcnt == r_delay) begin
              r_state  <= S_ACQ;
              r_acq_en <= 1'b1;
              r_tcnt   <= T_ONE;
            end else begin
              r_dcnt <= r_dcnt + D_ONE;
            end
          end
          S_ACQ: begin
            // procdone takes priority over a timeout landing in the same cycle.
            if (i_procdone) begin
              r_acq_en  <= 1'b0;
              r_shotcnt <= w_shotcnt_nxt;
              if (w_shotcnt_nxt == r_nshot) begin
                r_state        <= S_IDLE;
                r_busy         <= 1'b0;
                r_lastshotdone <= 1'b1;
              end else if (w_period_met) begin
                r_state <= S_TRIG;
                r_trig  <= 1'b1;
              end else begin
                r_state <= S_GAP;
              end
            end else if (r_timeout != '0 && r_tcnt == r_timeout) begin
              r_state       <= S_IDLE;
              r_acq_en      <= 1'b0;
              r_busy        <= 1'b0;
              r_timeout_err <= 1'b1;
            end else if (r_timeout != '0) begin
              r_tcnt <= r_tcnt + T_ONE;
            end
          end
          S_GAP: begin
            if (w_period_met) begin
              r_state <= S_TRIG;
              r_trig  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_trig         = r_trig;
  assign o_acq_en       = r_acq_en;
  assign o_accclear     = r_accclear;
  assign o_busy         = r_busy;
  assign o_shotcnt      = r_shotcnt;
  assign o_lastshotdone = r_lastshotdone;
  assign o_timeout_err  = r_timeout_err;
  assign o_aborted      = r_aborted;

endmodule

// File: tb/tb_shot_sequencer.sv
// tb/tb_shot_sequencer.sv - directed self-checking bench for shot_sequencer
module tb_shot_sequencer;

  logic        clk;
  logic        rst;
  logic        stb_start;
  logic        stb_abort;
  logic [31:0] nshot;
  logic        resetacc;
  logic [15:0] delayaftertrig;
  logic [23:0] shotperiod;
  logic [23:0] acqtimeout;
  logic        procdone;
  logic        o_trig;
  logic        o_acq_en;
  logic        o_accclear;
  logic        o_busy;
  logic [31:0] o_shotcnt;
  logic        o_lastshotdone;
  logic        o_timeout_err;
  logic        o_aborted;

  int total;
  int bad;

  int trig_a [0:127];
  int acq_a  [0:127];
  int busy_a [0:127];
  int last_a [0:127];
  int to_a   [0:127];
  int ab_a   [0:127];
  int sc_a   [0:127];
  int trig_q [$];
  int rise_q [$];
  int clr_q  [$];

  shot_sequencer dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_stb_start      (stb_start),
    .i_stb_abort      (stb_abort),
    .i_nshot          (nshot),
    .i_resetacc       (resetacc),
    .i_delayaftertrig (delayaftertrig),
    .i_shotperiod     (shotperiod),
    .i_acqtimeout     (acqtimeout),
    .i_procdone       (procdone),
    .o_trig           (o_trig),
    .o_acq_en         (o_acq_en),
    .o_accclear       (o_accclear),
    .o_busy           (o_busy),
    .o_shotcnt        (o_shotcnt),
    .o_lastshotdone   (o_lastshotdone),
    .o_timeout_err    (o_timeout_err),
    .o_aborted        (o_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int count_ones(input int a [0:127], input int n);
    int s;
    s = 0;
    for (int k = 0; k <= n; k++) s += a[k];
    return s;
  endfunction

  task automatic cfg(input int n, input int d, input int p, input int t, input logic ra);
    nshot          = 32'(n);
    delayaftertrig = 16'(d);
    shotperiod     = 24'(p);
    acqtimeout     = 24'(t);
    resetacc       = ra;
  endtask

  // Start strobe in cycle 0, then record outputs for cycles 1..ncyc; procdone pulses pd_dly cycles after each acq_en rise.
  task automatic run_seq(input int ncyc, input int pd_dly, input int abort_cyc, input int restart_cyc);
    int   pd_at;
    logic prev_acq;
    trig_q.delete();
    rise_q.delete();
    clr_q.delete();
    for (int k = 0; k < 128; k++) begin
      trig_a[k] = 0; acq_a[k] = 0; busy_a[k] = 0; last_a[k] = 0;
      to_a[k] = 0; ab_a[k] = 0; sc_a[k] = 0;
    end
    pd_at     = -1;
    prev_acq  = o_acq_en;
    stb_start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      stb_start = 1'b0;
      stb_abort = 1'b0;
      procdone  = 1'b0;
      trig_a[c] = int'(o_trig);
      acq_a[c]  = int'(o_acq_en);
      busy_a[c] = int'(o_busy);
      last_a[c] = int'(o_lastshotdone);
      to_a[c]   = int'(o_timeout_err);
      ab_a[c]   = int'(o_aborted);
      sc_a[c]   = int'(o_shotcnt);
      if (o_trig) trig_q.push_back(c);
      if (o_accclear) clr_q.push_back(c);
      if (o_acq_en && !prev_acq) begin
        rise_q.push_back(c);
        if (pd_dly >= 0) pd_at = c + pd_dly;
      end
      prev_acq = o_acq_en;
      if (c == pd_at) procdone = 1'b1;
      if (c == abort_cyc) stb_abort = 1'b1;
      if (c == restart_cyc) stb_start = 1'b1;
    end
    stb_start = 1'b0;
    stb_abort = 1'b0;
    procdone  = 1'b0;
  endtask

  initial begin
    int tcount;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    stb_start = 1'b0;
    stb_abort = 1'b0;
    procdone  = 1'b0;
    cfg(0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_trig", int'(o_trig), 0);
    check("rst_shotcnt", int'(o_shotcnt), 0);
    check("rst_last", int'(o_lastshotdone), 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // three shots, delay 4, period 20, accumulator clear
    cfg(3, 4, 20, 0, 1'b1);
    run_seq(70, 10, -1, -1);
    check("s1_clr_n", clr_q.size(), 1);
    check("s1_clr0", qget(clr_q, 0), 1);
    check("s1_trig_n", trig_q.size(), 3);
    check("s1_trig0", qget(trig_q, 0), 2);
    check("s1_trig1", qget(trig_q, 1), 22);
    check("s1_trig2", qget(trig_q, 2), 42);
    check("s1_rise0", qget(rise_q, 0), 7);
    check("s1_rise1", qget(rise_q, 1), 27);
    check("s1_rise2", qget(rise_q, 2), 47);
    check("s1_sc18", sc_a[18], 1);
    check("s1_sc38", sc_a[38], 2);
    check("s1_sc57", sc_a[57], 2);
    check("s1_sc58", sc_a[58], 3);
    check("s1_last57", last_a[57], 0);
    check("s1_last58", last_a[58], 1);
    check("s1_busy57", busy_a[57], 1);
    check("s1_busy58", busy_a[58], 0);

    // zero delay, period already exceeded at shot end, no clear
    cfg(2, 0, 5, 0, 1'b0);
    run_seq(80, 30, -1, -1);
    check("s2_clr_n", clr_q.size(), 0);
    check("s2_trig0", qget(trig_q, 0), 2);
    check("s2_trig1", qget(trig_q, 1), 34);
    check("s2_rise0", qget(rise_q, 0), 3);
    check("s2_rise1", qget(rise_q, 1), 35);
    check("s2_acq33", acq_a[33], 1);
    check("s2_acq34", acq_a[34], 0);
    check("s2_sc66", sc_a[66], 2);
    check("s2_last66", last_a[66], 1);
    check("s2_busy66", busy_a[66], 0);

    // acquisition timeout, no procdone
    cfg(5, 2, 0, 8, 1'b0);
    run_seq(30, -1, -1, -1);
    check("s3_rise0", qget(rise_q, 0), 5);
    check("s3_acq_cycles", count_ones(acq_a, 30), 8);
    check("s3_trig_n", trig_q.size(), 1);
    check("s3_to12", to_a[12], 0);
    check("s3_to13", to_a[13], 1);
    check("s3_sc13", sc_a[13], 0);
    check("s3_last13", last_a[13], 0);
    check("s3_busy13", busy_a[13], 0);

    // abort during the delay of shot 3
    cfg(100, 4, 0, 0, 1'b0);
    run_seq(40, 3, 22, -1);
    check("s4_trig2", qget(trig_q, 2), 20);
    check("s4_trig_n", trig_q.size(), 3);
    check("s4_busy22", busy_a[22], 1);
    check("s4_busy23", busy_a[23], 0);
    check("s4_ab22", ab_a[22], 0);
    check("s4_ab23", ab_a[23], 1);
    check("s4_sc23", sc_a[23], 2);
    check("s4_sc40", sc_a[40], 2);

    // restart after abort clears status
    cfg(1, 0, 0, 0, 1'b0);
    run_seq(12, 2, -1, -1);
    check("s4b_ab1", ab_a[1], 0);
    check("s4b_sc1", sc_a[1], 0);
    check("s4b_sc6", sc_a[6], 1);
    check("s4b_last6", last_a[6], 1);

    // nshot = 0
    cfg(0, 0, 0, 0, 1'b1);
    run_seq(10, 2, -1, -1);
    check("s5_last1", last_a[1], 1);
    check("s5_trig_n", trig_q.size(), 0);
    check("s5_busy_cycles", count_ones(busy_a, 10), 0);
    check("s5_clr_n", clr_q.size(), 0);

    // start strobe while busy is ignored
    cfg(2, 0, 0, 0, 1'b0);
    run_seq(25, 5, -1, 4);
    check("s5b_trig0", qget(trig_q, 0), 2);
    check("s5b_trig1", qget(trig_q, 1), 9);
    check("s5b_sc9", sc_a[9], 1);
    check("s5b_sc16", sc_a[16], 2);
    check("s5b_last16", last_a[16], 1);

    // procdone on the timeout cycle counts the shot
    cfg(2, 0, 0, 8, 1'b0);
    run_seq(30, 7, -1, -1);
    check("s7_sc11", sc_a[11], 1);
    check("s7_to11", to_a[11], 0);
    check("s7_sc20", sc_a[20], 2);
    check("s7_last20", last_a[20], 1);
    check("s7_to20", to_a[20], 0);

    // asynchronous reset during ACQ
    cfg(3, 0, 0, 0, 1'b0);
    run_seq(8, 2, -1, -1);
    check("s6_pre_acq", int'(o_acq_en), 1);
    check("s6_pre_sc", int'(o_shotcnt), 1);
    #2 rst = 1'b1;
    #1;
    check("s6_acq", int'(o_acq_en), 0);
    check("s6_busy", int'(o_busy), 0);
    check("s6_sc", int'(o_shotcnt), 0);
    check("s6_trig", int'(o_trig), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tcount = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      tcount += int'(o_trig);
    end
    check("s6_no_trig", tcount, 0);
    check("s6_busy_after", int'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Per-run controller for the DSP datapath.
- Turns a single start strobe from the DSP register bank into nshot trigger/acquire cycles.
- Each shot produces: a trigger pulse, a programmable post-trigger delay, an acquisition window that closes on the datapath's procdone, and an enforced minimum shot period.
- Reports shot count and run status back to the register bank. Sits between the DSP registers and the DSP core, on dspclk.

Parameters:
NSHOT_WIDTH, 32, width of nshot and shotcnt
DELAY_WIDTH, 16, width of delayaftertrig
PERIOD_WIDTH, 24, width of shotperiod and the internal period counter
TIMEOUT_WIDTH, 24, width of acqtimeout and the internal timeout counter

Ports:
clk  input  1  DSP clock
reset  input  1  asynchronous, active-high reset
stb_start  input  1  one-cycle start strobe
stb_abort  input  1  one-cycle abort strobe
nshot  input  NSHOT_WIDTH  shots per run; sampled at start
resetacc  input  1  1 = clear accumulators at run start; sampled at start
delayaftertrig  input  DELAY_WIDTH  cycles from trigger to acquisition; sampled at start
shotperiod  input  PERIOD_WIDTH  minimum trigger-to-trigger spacing in cycles; sampled at start
acqtimeout  input  TIMEOUT_WIDTH  maximum acquisition window length; 0 = disabled; sampled at start
procdone  input  1  datapath finished the current shot (level or pulse)
trig  output  1  one-cycle trigger pulse per shot
acq_en  output  1  acquisition window
accclear  output  1  one-cycle accumulator clear
busy  output  1  run in progress
shotcnt  output  NSHOT_WIDTH  completed shots in the current or last run
lastshotdone  output  1  run completed normally
timeout_err  output  1  sticky; run ended on timeout
aborted  output  1  sticky; run ended on abort

Behaviour:
- Reset: state IDLE. All outputs are 0; all counters and latched configuration are 0.
- States: IDLE, ARM, TRIG, DELAY, ACQ, GAP.
- IDLE:
  - stb_start at cycle S: latch configuration; clear shotcnt, lastshotdone, timeout_err and aborted; go to ARM.
  - If the latched nshot = 0: set lastshotdone=1 at S+1 and stay in IDLE; trig never pulses.
- ARM (cycle S+1): busy=1; accclear=1 for this cycle only if resetacc=1. Go to TRIG.
- TRIG (cycle T, first T = S+2): trig=1 for one cycle. Period counter loads 1. Go to DELAY, or directly to ACQ if delayaftertrig=0.
- DELAY: counts delayaftertrig cycles, so acq_en first rises at cycle T+1+delayaftertrig.
- ACQ:
  - acq_en=1; the timeout counter increments each cycle.
  - procdone=1 at cycle P: acq_en drops at P+1 and shotcnt increments at P+1.
  - If shotcnt+1 == nshot: go to IDLE at P+1 with lastshotdone=1 and busy=0 at P+1. Otherwise go to GAP.
  - Timeout: acqtimeout != 0, acq_en has been high for acqtimeout cycles, and procdone is not seen. Then go to IDLE, set timeout_err=1, leave shotcnt unchanged, keep lastshotdone=0.
  - procdone in the same cycle as timeout: procdone wins.
- GAP: the next TRIG occurs at max(P+1, T+shotperiod). shotperiod 0 or 1 means no extra spacing.
- Period counter: increments every cycle from TRIG and saturates at all-ones; it never wraps.
- Abort: stb_abort in any non-IDLE state forces IDLE next cycle.
  - acq_en and busy are 0 that cycle; aborted=1; shotcnt holds.
  - A trig or accclear scheduled for that same cycle is suppressed.
  - stb_abort in IDLE is ignored.
- stb_start while busy is ignored.
- stb_start and stb_abort in the same cycle in IDLE: the start is taken.
- procdone outside ACQ is ignored. procdone held high means one shot per ACQ entry.
- Asynchronous reset mid-run: everything clears immediately, with no glitch pulse on trig on deassertion.
- trig, accclear and acq_en are registered outputs. There is no combinational path from inputs to outputs.
- Status outputs hold after run end until the next accepted start.

Test Plan:
- nshot=3, delayaftertrig=4, shotperiod=20, resetacc=1, procdone pulsed 10 cycles after each acq_en rise, start at cycle 0 -> accclear at 1; trig at 2, 22, 42; acq_en rises at 7, 27, 47; shotcnt steps 1, 2, 3; lastshotdone=1 and busy=0 at cycle 18+40=58.
- nshot=2, delay=0, shotperiod=5, procdone 30 cycles after acq_en -> acq_en at T+1; second trig one cycle after the first shot's ACQ exit (period already exceeded); resetacc=0 gives no accclear.
- nshot=5, acqtimeout=8, procdone never asserted -> acq_en high exactly 8 cycles; then timeout_err=1, shotcnt=0, lastshotdone=0, busy=0.
- nshot=100, stb_abort during the DELAY of shot 3 -> busy=0 next cycle, aborted=1, shotcnt=2, no further trig; a following stb_start clears aborted and restarts.
- nshot=0 -> lastshotdone=1 at S+1, no trig, busy stays 0; stb_start issued while busy mid-run -> no effect on counters.
- Reset asserted during ACQ, and procdone coincident with the timeout cycle -> all outputs 0 immediately on reset; in the coincident case the shot is counted and timeout_err stays 0.
